// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl: RV32I multicycle control FSM with immediate generator.
// Define RV_BRANCH_EN to support BEQ/BNE; otherwise opcode 1100011 traps.
module rv_multicycle_ctrl #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           instr,
   input  logic                  mem_ready,
   input  logic                  alu_zero,
   output logic [3:0]            alu_op,
   output logic                  alu_src_a,
   output logic [1:0]            alu_src_b,
   output logic [DATA_WIDTH-1:0] imm,
   output logic                  ir_we,
   output logic                  pc_we,
   output logic                  rf_we,
   output logic                  pc_src,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic                  wb_sel,
   output logic                  illegal
);
   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_LTU = 4'd2;
   localparam logic [3:0] OP_SLL = 4'd3;
   localparam logic [3:0] OP_SRL = 4'd4;
   localparam logic [3:0] OP_SRA = 4'd5;
   localparam logic [3:0] OP_AND = 4'd6;
   localparam logic [3:0] OP_OR  = 4'd7;
   localparam logic [3:0] OP_XOR = 4'd8;
   localparam logic [3:0] OP_LUI = 4'd9;

   localparam logic [6:0] OPC_R     = 7'b0110011;
   localparam logic [6:0] OPC_I     = 7'b0010011;
   localparam logic [6:0] OPC_LW    = 7'b0000011;
   localparam logic [6:0] OPC_SW    = 7'b0100011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;
   localparam logic [6:0] OPC_BR    = 7'b1100011;

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_TRAP
   } state_t;

   typedef enum logic [2:0] {
      C_R, C_I, C_LW, C_SW, C_LUI, C_AUIPC, C_BR, C_BAD
   } cls_t;

   state_t      state_q;
   state_t      state_d;
   cls_t        cls;
   logic [3:0]  fop;
   logic [31:0] imm32;
   logic [6:0]  opcode;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic        f7_zero;
   logic        f7_alt;
   logic        shift_op;
   logic        taken;
   logic        unused_rs1;

   assign opcode     = instr[6:0];
   assign f3         = instr[14:12];
   assign f7         = instr[31:25];
   assign f7_zero    = (f7 == 7'b0000000);
   assign f7_alt     = (f7 == 7'b0100000);
   assign shift_op   = (f3 == 3'b001) || (f3 == 3'b101);
   assign taken      = alu_zero ^ f3[0];
   assign unused_rs1 = ^instr[19:15];

   always_comb begin
      unique case (f3)
         3'b000:  fop = (opcode == OPC_R && f7_alt) ? OP_SUB : OP_ADD;
         3'b001:  fop = OP_SLL;
         3'b011:  fop = OP_LTU;
         3'b100:  fop = OP_XOR;
         3'b101:  fop = f7_alt ? OP_SRA : OP_SRL;
         3'b110:  fop = OP_OR;
         3'b111:  fop = OP_AND;
         default: fop = OP_ADD;
      endcase
   end

   always_comb begin
      cls = C_BAD;
      case (opcode)
         OPC_R:
            if (f3 != 3'b010 && (f7_zero ||
                (f7_alt && (f3 == 3'b000 || f3 == 3'b101))))
               cls = C_R;
         OPC_I:
            if (f3 != 3'b010 && (!shift_op || f7_zero ||
                (f7_alt && f3 == 3'b101)))
               cls = C_I;
         OPC_LW:    if (f3 == 3'b010) cls = C_LW;
         OPC_SW:    if (f3 == 3'b010) cls = C_SW;
         OPC_LUI:   cls = C_LUI;
         OPC_AUIPC: cls = C_AUIPC;
`ifdef RV_BRANCH_EN
         OPC_BR:    if (f3[2:1] == 2'b00) cls = C_BR;
`endif
         default:   cls = C_BAD;
      endcase
   end

   always_comb begin
      imm32 = '0;
      case (opcode)
         OPC_I:
            imm32 = shift_op ? {27'd0, instr[24:20]}
                             : {{20{instr[31]}}, instr[31:20]};
         OPC_LW:
            imm32 = {{20{instr[31]}}, instr[31:20]};
         OPC_SW:
            imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         OPC_BR:
            imm32 = {{19{instr[31]}}, instr[31], instr[7],
                     instr[30:25], instr[11:8], 1'b0};
         OPC_LUI, OPC_AUIPC:
            imm32 = {instr[31:12], 12'd0};
         default:
            imm32 = '0;
      endcase
   end

   assign imm = rst ? '0 : {{(DATA_WIDTH-31){imm32[31]}}, imm32[30:0]};

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_FETCH;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      alu_op    = OP_ADD;
      alu_src_a = 1'b0;
      alu_src_b = 2'd0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      rf_we     = 1'b0;
      pc_src    = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      wb_sel    = 1'b0;
      illegal   = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_we   = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            pc_we     = 1'b1;
            state_d   = (cls == C_BAD) ? S_TRAP : S_EXECUTE;
         end
         S_EXECUTE: begin
            state_d = S_WB;
            unique case (cls)
               C_R: alu_op = fop;
               C_I: begin
                  alu_op    = fop;
                  alu_src_b = 2'd1;
               end
               C_LW, C_SW: begin
                  alu_src_b = 2'd1;
                  state_d   = S_MEM;
               end
               C_LUI: begin
                  alu_op    = OP_LUI;
                  alu_src_b = 2'd1;
               end
               C_AUIPC: begin
                  alu_src_a = 1'b1;
                  alu_src_b = 2'd1;
               end
               C_BR: begin
                  alu_op  = OP_SUB;
                  pc_we   = taken;
                  pc_src  = taken;
                  state_d = S_FETCH;
               end
               default: state_d = S_TRAP;
            endcase
         end
         S_MEM: begin
            mem_req = 1'b1;
            mem_we  = (cls == C_SW);
            if (mem_ready)
               state_d = (cls == C_SW) ? S_FETCH : S_WB;
         end
         S_WB: begin
            rf_we   = 1'b1;
            wb_sel  = (cls == C_LW);
            state_d = S_FETCH;
         end
         S_TRAP: illegal = 1'b1;
         default: state_d = S_FETCH;
      endcase
      // reset wins over every state so nothing is issued while held
      if (rst) begin
         alu_op    = OP_ADD;
         alu_src_a = 1'b0;
         alu_src_b = 2'd0;
         ir_we     = 1'b0;
         pc_we     = 1'b0;
         rf_we     = 1'b0;
         pc_src    = 1'b0;
         mem_req   = 1'b0;
         mem_we    = 1'b0;
         wb_sel    = 1'b0;
         illegal   = 1'b0;
      end
   end
endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Bench for rv_multicycle_ctrl: per-instruction cycle expectations built
// from the instruction class, compared on every falling edge.
module tb_rv_multicycle_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] instr = '0;
   logic        mem_ready = 1'b0;
   logic        alu_zero = 1'b0;
   logic [3:0]  alu_op;
   logic        alu_src_a;
   logic [1:0]  alu_src_b;
   logic [31:0] imm;
   logic        ir_we, pc_we, rf_we, pc_src;
   logic        mem_req, mem_we, wb_sel, illegal;

   always #5 clk = ~clk;

   rv_multicycle_ctrl #(.DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .instr(instr),
      .mem_ready(mem_ready), .alu_zero(alu_zero),
      .alu_op(alu_op), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .imm(imm),
      .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we),
      .pc_src(pc_src), .mem_req(mem_req), .mem_we(mem_we),
      .wb_sel(wb_sel), .illegal(illegal)
   );

   typedef struct packed {
      logic [3:0]  alu_op;
      logic        alu_src_a;
      logic [1:0]  alu_src_b;
      logic [31:0] imm;
      logic        ir_we, pc_we, rf_we, pc_src;
      logic        mem_req, mem_we, wb_sel, illegal;
   } vec_t;

   typedef enum {K_R, K_I, K_LW, K_SW, K_LUI, K_AUIPC, K_BR, K_BAD} kind_e;

   typedef struct {
      logic [31:0] base;
      logic [31:0] mask;
      kind_e       k;
      logic [3:0]  op;
   } tmpl_t;

`ifdef RV_BRANCH_EN
   localparam kind_e K_BRK = K_BR;
`else
   localparam kind_e K_BRK = K_BAD;
`endif

   localparam logic [31:0] RM = 32'h01FF_8F80;
   localparam logic [31:0] IM = 32'hFFFF_8F80;
   localparam logic [31:0] UM = 32'hFFFF_FF80;

   vec_t   exp_v;
   vec_t   act_v;
   bit     exp_on = 0;
   string  tag = "reset";
   int     n_vec = 0;
   int     n_bad = 0;
   tmpl_t  tbl[$];

   assign act_v = {alu_op, alu_src_a, alu_src_b, imm, ir_we, pc_we,
                   rf_we, pc_src, mem_req, mem_we, wb_sel, illegal};

   always @(negedge clk) begin
      if (exp_on) begin
         n_vec++;
         if (act_v !== exp_v) begin
            n_bad++;
            $display("FAIL %s: instr=%h outputs=%h expected=%h",
                     tag, instr, act_v, exp_v);
         end
      end
   end

   function automatic logic [31:0] enc(input logic [6:0] f7,
                                       input logic [2:0] f3,
                                       input logic [6:0] opc);
      return {f7, 10'd0, f3, 5'd0, opc};
   endfunction

   function automatic logic [31:0] ref_imm(input logic [31:0] i);
      logic [2:0] f3;
      f3 = i[14:12];
      case (i[6:0])
         7'b0010011:
            if (f3 == 3'd1 || f3 == 3'd5) return {27'd0, i[24:20]};
            else return {{20{i[31]}}, i[31:20]};
         7'b0000011: return {{20{i[31]}}, i[31:20]};
         7'b0100011: return {{20{i[31]}}, i[31:25], i[11:7]};
         7'b1100011:
            return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         7'b0110111, 7'b0010111: return {i[31:12], 12'd0};
         default: return 32'd0;
      endcase
   endfunction

   task automatic add(input logic [31:0] b, input logic [31:0] m,
                      input kind_e k, input logic [3:0] op);
      tmpl_t t;
      t.base = b; t.mask = m; t.k = k; t.op = op;
      tbl.push_back(t);
   endtask

   task automatic pin(input string name, input logic [31:0] got,
                      input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h", name, got, want);
      end
   endtask

   task automatic step(input vec_t e, input logic mr, input logic az);
      e.imm = rst ? 32'd0 : ref_imm(instr);
      exp_v = e;
      mem_ready = mr;
      alu_zero = az;
      exp_on = 1;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      vec_t e;
      rst = 1'b1;
      for (int i = 0; i < n; i++) begin
         e = '0;
         step(e, 1'($urandom), 1'($urandom));
      end
      rst = 1'b0;
   endtask

   task automatic fetch(input logic [31:0] ins, input int wf);
      vec_t e;
      for (int i = 0; i < wf; i++) begin
         e = '0; e.mem_req = 1;
         step(e, 1'b0, 1'($urandom));
      end
      e = '0; e.mem_req = 1; e.ir_we = 1;
      step(e, 1'b1, 1'($urandom));
      instr = ins;
      e = '0; e.alu_src_a = 1; e.alu_src_b = 2'd2; e.pc_we = 1;
      step(e, 1'($urandom), 1'($urandom));
   endtask

   task automatic run_instr(input logic [31:0] ins, input kind_e k,
                            input logic [3:0] op, input int wf,
                            input int wm, input int zsel);
      vec_t e;
      logic z;
      logic tk;
      fetch(ins, wf);
      if (k == K_BAD) begin
         repeat ($urandom_range(2, 5)) begin
            e = '0; e.illegal = 1;
            step(e, 1'($urandom), 1'($urandom));
         end
         do_reset($urandom_range(1, 2));
         return;
      end
      z = (zsel == 2) ? 1'($urandom) : 1'(zsel);
      e = '0;
      case (k)
         K_R: e.alu_op = op;
         K_I: begin e.alu_op = op; e.alu_src_b = 2'd1; end
         K_LW, K_SW: e.alu_src_b = 2'd1;
         K_LUI: begin e.alu_op = 4'd9; e.alu_src_b = 2'd1; end
         K_AUIPC: begin e.alu_src_a = 1; e.alu_src_b = 2'd1; end
         K_BR: begin
            e.alu_op = 4'd1;
            tk = (ins[12] == 1'b0) ? z : !z;
            e.pc_we = tk; e.pc_src = tk;
         end
         default: ;
      endcase
      step(e, 1'($urandom), z);
      if (k == K_LW || k == K_SW) begin
         e = '0; e.mem_req = 1; e.mem_we = (k == K_SW);
         for (int i = 0; i < wm; i++) step(e, 1'b0, 1'($urandom));
         step(e, 1'b1, 1'($urandom));
      end
      if (k != K_SW && k != K_BR) begin
         e = '0; e.rf_we = 1; e.wb_sel = (k == K_LW);
         step(e, 1'($urandom), 1'($urandom));
      end
   endtask

   initial begin
      tmpl_t t;
      logic [31:0] ins;
      vec_t e;
      add(enc(7'h00, 3'd0, 7'h33), RM, K_R, 4'd0);
      add(enc(7'h20, 3'd0, 7'h33), RM, K_R, 4'd1);
      add(enc(7'h00, 3'd1, 7'h33), RM, K_R, 4'd3);
      add(enc(7'h00, 3'd3, 7'h33), RM, K_R, 4'd2);
      add(enc(7'h00, 3'd4, 7'h33), RM, K_R, 4'd8);
      add(enc(7'h00, 3'd5, 7'h33), RM, K_R, 4'd4);
      add(enc(7'h20, 3'd5, 7'h33), RM, K_R, 4'd5);
      add(enc(7'h00, 3'd6, 7'h33), RM, K_R, 4'd7);
      add(enc(7'h00, 3'd7, 7'h33), RM, K_R, 4'd6);
      add(enc(7'h00, 3'd0, 7'h13), IM, K_I, 4'd0);
      add(enc(7'h00, 3'd3, 7'h13), IM, K_I, 4'd2);
      add(enc(7'h00, 3'd4, 7'h13), IM, K_I, 4'd8);
      add(enc(7'h00, 3'd6, 7'h13), IM, K_I, 4'd7);
      add(enc(7'h00, 3'd7, 7'h13), IM, K_I, 4'd6);
      add(enc(7'h00, 3'd1, 7'h13), RM, K_I, 4'd3);
      add(enc(7'h00, 3'd5, 7'h13), RM, K_I, 4'd4);
      add(enc(7'h20, 3'd5, 7'h13), RM, K_I, 4'd5);
      add(enc(7'h00, 3'd2, 7'h03), IM, K_LW, 4'd0);
      add(enc(7'h00, 3'd2, 7'h23), IM, K_SW, 4'd0);
      add(enc(7'h00, 3'd0, 7'h37), UM, K_LUI, 4'd9);
      add(enc(7'h00, 3'd0, 7'h17), UM, K_AUIPC, 4'd0);
      add(enc(7'h00, 3'd0, 7'h63), IM, K_BRK, 4'd1);
      add(enc(7'h00, 3'd1, 7'h63), IM, K_BRK, 4'd1);
      add(enc(7'h00, 3'd4, 7'h63), IM, K_BAD, 4'd0);
      add(32'h0000_007F, UM, K_BAD, 4'd0);
      add(enc(7'h00, 3'd2, 7'h33), RM, K_BAD, 4'd0);
      add(enc(7'h00, 3'd2, 7'h13), IM, K_BAD, 4'd0);
      add(enc(7'h01, 3'd0, 7'h33), RM, K_BAD, 4'd0);
      add(enc(7'h20, 3'd6, 7'h33), RM, K_BAD, 4'd0);
      add(enc(7'h20, 3'd1, 7'h13), RM, K_BAD, 4'd0);
      add(enc(7'h00, 3'd0, 7'h03), IM, K_BAD, 4'd0);

      pin("imm_srai", ref_imm(32'h4032_D293), 32'd3);
      pin("imm_lw_neg", ref_imm(32'hFFC1_2083), 32'hFFFF_FFFC);
      pin("imm_sw", ref_imm(32'h0011_2423), 32'd8);
      pin("imm_beq", ref_imm(32'h0020_8463), 32'd8);
      pin("imm_lui", ref_imm(32'h1234_5037), 32'h1234_5000);

      @(posedge clk);
      #1;
      tag = "reset";
      do_reset(2);

      tag = "add";
      run_instr(32'h0020_81B3, K_R, 4'd0, 0, 0, 2);
      tag = "srai";
      run_instr(32'h4032_D293, K_I, 4'd5, 0, 0, 2);
      tag = "lw_wait3";
      run_instr(32'h0001_2083, K_LW, 4'd0, 0, 3, 2);
      tag = "beq_taken";
      run_instr(32'h0020_8463, K_BRK, 4'd1, 0, 0, 1);
      tag = "sw_wait";
      run_instr(32'h0011_2423, K_SW, 4'd0, 2, 1, 2);
      tag = "undef_7f";
      run_instr(32'h0000_007F, K_BAD, 4'd0, 1, 0, 2);

      tag = "sw_abort";
      fetch(32'h0011_2423, 0);
      e = '0; e.alu_src_b = 2'd1;
      step(e, 1'($urandom), 1'($urandom));
      e = '0; e.mem_req = 1; e.mem_we = 1;
      step(e, 1'b0, 1'($urandom));
      do_reset(2);
      run_instr(32'h0020_81B3, K_R, 4'd0, 0, 0, 2);

      tag = "random";
      for (int n = 0; n < 400; n++) begin
         t = tbl[$urandom_range(0, tbl.size() - 1)];
         ins = t.base | ($urandom & t.mask);
         run_instr(ins, t.k, t.op,
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                   ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0,
                   2);
      end

      exp_on = 0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/rv_multicycle_ctrl.md
# rv_multicycle_ctrl

Multicycle control FSM that sequences each RV32I instruction through fetch, decode, execute, memory and writeback, and drives the ALU's operation select and operand muxes. It sits between the instruction register / memory port and the datapath (register file, PC, ALU). It is the command-issuing side of the ALU interface: it decides which op the ALU performs each cycle and consumes the ALU's zero flag for branches.

## Interface
- Parameters:
  - `DATA_WIDTH`, 32, datapath width; sets the width of `imm`.
- Ports:
  - `clk`  in  1  single clock; all state changes on the rising edge.
  - `rst`  in  1  synchronous, active-high reset.
  - `instr`  in  32  instruction register contents; valid from DECODE onward.
  - `mem_ready`  in  1  memory handshake complete; sampled in FETCH and MEM.
  - `alu_zero`  in  1  ALU Z flag.
  - `alu_op`  out  4  ALU op: ADD=0, SUB=1, LTU=2, SLL=3, SRL=4, SRA=5, AND=6, OR=7, XOR=8, LUI=9.
  - `alu_src_a`  out  1  0 = rs1, 1 = PC.
  - `alu_src_b`  out  2  0 = rs2, 1 = imm, 2 = constant 4.
  - `imm`  out  DATA_WIDTH  sign-extended immediate (I/S/B/U format, per opcode).
  - `ir_we`, `pc_we`, `rf_we`  out  1 each  register write strobes.
  - `pc_src`  out  1  0 = ALU result, 1 = branch target (PC_old + imm, external adder).
  - `mem_req`, `mem_we`  out  1 each  memory request; write when `mem_we`=1.
  - `wb_sel`  out  1  0 = ALU result, 1 = load data.
  - `illegal`  out  1  sticky illegal-instruction flag.

## Operation
- States: FETCH, DECODE, EXECUTE, MEM, WB, TRAP.
- FETCH: `mem_req`=1, `mem_we`=0. Stay while `mem_ready`=0. On `mem_ready`=1: `ir_we`=1, go to DECODE.
- DECODE: ALU computes PC+4 (`alu_src_a`=1, `alu_src_b`=2, ADD); `pc_we`=1, `pc_src`=0. Unsupported opcode/funct goes to TRAP; otherwise EXECUTE.
- EXECUTE:
  - R-type (ADD, SUB, SLTU, SLL, SRL, SRA, AND, OR, XOR): src rs1/rs2, op from funct3/funct7. Next state WB.
  - I-type ALU (ADDI, SLTIU, ANDI, ORI, XORI, SLLI, SRLI, SRAI): src_b = imm. Next state WB.
  - LW/SW: ADD rs1+imm. Next state MEM.
  - LUI: op LUI, src_b = imm. AUIPC: ADD with PC and imm. Next state WB.
- MEM: `mem_req`=1, `mem_we`=1 for SW. Hold until `mem_ready`. Then SW goes to FETCH, LW goes to WB.
- WB: `rf_we`=1, `wb_sel`=1 for LW, else 0. Next state FETCH.
- TRAP: `illegal`=1, all strobes 0. Stays in TRAP until `rst`.
- Default outside listed cases: `alu_op`=ADD, `alu_src_a`=0, `alu_src_b`=0, all strobes 0.
- ALU overflow is not an input and never traps (RV32I semantics).
- `imm` is a combinational function of `instr` only.

## Timing
- `rst`=1 at an edge: state returns to FETCH. While `rst` is high, every output is forced to 0, including `illegal` and `mem_req`.
- Reset mid-operation (including while `mem_req` is pending) abandons the instruction with no strobe issued. The first cycle after deassertion is FETCH with `mem_req`=1.
- All outputs are combinational from the state register and `instr` (Moore per state); no output depends on `mem_ready` except the FETCH `ir_we` and the MEM exit.
- Cycles per instruction with zero-wait memory (`mem_ready`=1 in the first request cycle):
  - ALU, LUI, AUIPC: 4.
  - LW: 5.
  - SW: 4.
  - Branch: 3.
  - Each wait cycle adds 1.
- `mem_req` stays high continuously from request until the cycle `mem_ready` is seen. `mem_ready` outside FETCH/MEM is ignored.

## Configuration
- `RV_BRANCH_EN` defined: BEQ/BNE are supported.
  - EXECUTE computes SUB rs1-rs2.
  - Taken (BEQ with `alu_zero`=1, BNE with `alu_zero`=0) asserts `pc_we`=1 and `pc_src`=1.
  - Next state is always FETCH.
- Undefined: opcode 1100011 is illegal and goes to TRAP.

## Test plan
- Reset: hold `rst` 2 cycles during MEM of an SW -> all outputs 0; after release FETCH, `mem_req`=1, `mem_we`=0.
- ADD x3,x1,x2 (0x002081B3), `mem_ready`=1 -> `ir_we` at cycle 0; `pc_we` with `alu_src_b`=2 at cycle 1; `alu_op`=0 at cycle 2; `rf_we` at cycle 3.
- SRAI x5,x5,3 (0x4032D293) -> EXECUTE `alu_op`=5, `alu_src_b`=1, `imm`=3.
- LW with `mem_ready` low 3 cycles in MEM -> `mem_req` held 4 cycles; then WB with `wb_sel`=1; total 8 cycles.
- BEQ (0x00208463), `alu_zero`=1 -> `alu_op`=1, `pc_we`=1, `pc_src`=1, back to FETCH in 3 cycles. Without `RV_BRANCH_EN` -> TRAP, `illegal`=1 until reset.
- Undefined opcode 0x0000007F -> TRAP after DECODE; no `rf_we` or `mem_req` thereafter.
